// File: rtl/range_deser.sv
// range_deser: serial-to-parallel word assembler with optional two's-complement
// negation, a one-word output holding register with valid/ready handshake,
// abort of a partial word, and a modulo-256 count of delivered words.
module range_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_neg,
  output logic             in_ready,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       word_cnt
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FULL
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] bit_idx;
  logic             neg_flag;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word_next;
  logic [WIDTH-1:0] word_final;
  logic             pop;
  logic             accept;
  logic             last_bit;
  logic             neg_eff;

  // A held word blocks input unless the consumer drains it in the same cycle,
  // which is what lets back-to-back words flow without a bubble.
  assign in_ready = !out_valid || out_ready;
  assign pop      = out_valid && out_ready;
  assign accept   = in_valid && in_ready && !abort;
  assign last_bit = (bit_idx == LAST_IDX);
  // The negate request only matters on the first bit; afterwards the latched copy rules.
  assign neg_eff  = (bit_idx == '0) ? in_neg : neg_flag;

  // Assembly register with the incoming bit dropped into its slot.
  always_comb begin
    word_next = shreg;
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST ? (i == (WIDTH - 1 - int'(bit_idx))) : (i == int'(bit_idx))) begin
        word_next[i] = in_bit;
      end
    end
    word_final = neg_eff ? (~word_next + WIDTH'(1)) : word_next;
  end

  // Control FSM together with the datapath registers it owns.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_idx   <= '0;
      neg_flag  <= 1'b0;
      shreg     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      word_cnt  <= '0;
    end else begin
      if (pop) begin
        out_valid <= 1'b0;
        word_cnt  <= word_cnt + 8'd1;
      end

      if (abort) begin
        bit_idx  <= '0;
        neg_flag <= 1'b0;
      end else if (accept) begin
        shreg <= word_next;
        if (last_bit) begin
          bit_idx   <= '0;
          neg_flag  <= 1'b0;
          out_valid <= 1'b1;
          out_data  <= word_final;
        end else begin
          bit_idx  <= bit_idx + IDX_W'(1);
          neg_flag <= neg_eff;
        end
      end

      case (state)
        IDLE: begin
          if (accept) state <= SHIFT;
        end
        SHIFT: begin
          if (abort) state <= IDLE;
          else if (accept && last_bit) state <= FULL;
        end
        FULL: begin
          if (pop) state <= accept ? SHIFT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/range_deser.md
RANGE_DESER -- requirements
Module: range_deser

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the word width in bits (legal range 2..32).
REQ-002 The module SHALL have parameter MSB_FIRST, default 1: 1 places the first received bit at the left (WIDTH-1, "downto" order); 0 places it at bit 0 ("to" order).
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  serial bit present on in_bit.
REQ-006 in_bit  input  1  serial data bit.
REQ-007 in_neg  input  1  negate request, sampled only with the first accepted bit of a word.
REQ-008 in_ready  output  1  module can accept a bit this cycle.
REQ-009 abort  input  1  discard the partial word in progress.
REQ-010 out_valid  output  1  out_data holds a complete word.
REQ-011 out_ready  input  1  consumer takes the word this cycle.
REQ-012 out_data  output  WIDTH  assembled word, optionally negated.
REQ-013 word_cnt  output  8  count of words delivered, modulo 256.

Function
REQ-014 Accept: a bit SHALL be accepted exactly on cycles with in_valid=1 and in_ready=1.
REQ-015 Ready rule: in_ready SHALL be combinational: !out_valid || out_ready.
REQ-016 Bit counter: bit_idx SHALL run 0..WIDTH-1, increment per accepted bit, and return to 0 after the WIDTH-th bit.
REQ-017 Placement: accepted bit k (0-based) SHALL go to position WIDTH-1-k if MSB_FIRST=1, else to position k.
REQ-018 Negate flag: in_neg SHALL be latched on the bit with bit_idx=0 and held for the rest of that word.
REQ-019 Completion: on the cycle after the WIDTH-th accepted bit, out_valid SHALL be 1 and out_data SHALL equal the assembled word.
REQ-020 Negation: if the latched negate flag is 1, out_data SHALL be the two's-complement negation modulo 2^WIDTH (0 maps to 0; 2^(WIDTH-1) maps to itself).
REQ-021 Latency: the latency from the last accepted bit to out_valid SHALL be 1 cycle.
REQ-022 Hold: while out_valid=1 and out_ready=0, out_data, out_valid and the assembly register SHALL stay unchanged, and no bit SHALL be accepted.
REQ-023 Pop: out_valid=1 with out_ready=1 SHALL clear out_valid next cycle, unless a new word completes in the same cycle.
REQ-024 Word count: each pop SHALL increment word_cnt, wrapping 255 to 0.
REQ-025 Simultaneous pop and accept: a bit accepted in the pop cycle SHALL become a bit of the next word, enabling back-to-back words with no bubble.
REQ-026 States: the FSM SHALL have three states.
  - IDLE: bit_idx=0, out_valid=0.
  - SHIFT: 0<bit_idx<WIDTH.
  - FULL: out_valid=1.
REQ-027 Transitions: the FSM SHALL move as follows.
  - IDLE to SHIFT on an accept.
  - SHIFT to FULL on the WIDTH-th accept.
  - FULL to IDLE on pop with no accept.
  - FULL to SHIFT on pop with an accept.
REQ-028 Abort: abort=1 SHALL clear bit_idx and the negate flag, return SHIFT to IDLE, and ignore any bit presented that cycle.
REQ-029 Abort while FULL: abort SHALL not affect a completed word held in FULL.
REQ-030 Abort priority: abort SHALL take priority over accept in the same cycle.

Reset
REQ-031 rst=1 SHALL force the following next cycle, taking priority over all other inputs.
  - State IDLE, bit_idx=0, negate flag 0.
  - out_valid=0, out_data=0, word_cnt=0.
REQ-032 Reset mid-word or while FULL SHALL discard all partial and held data.
REQ-033 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-034 WIDTH=4, MSB_FIRST=1, bits 0,0,1,1, in_neg=0 -> out_valid=1 one cycle after the 4th bit, out_data=4'b0011, word_cnt=1 after pop.
REQ-035 WIDTH=4, MSB_FIRST=0, bits 1,0,0,0 -> out_data=4'b0001.
REQ-036 MSB_FIRST=1, bits 1,1,0,1 with in_neg=1 on the first bit -> out_data=4'b0011; bits 1,0,0,0 with neg -> 4'b1000.
REQ-037 Backpressure test: word complete, out_ready=0 for 3 cycles -> in_ready=0 and out_data stable; out_ready=1 with a bit offered the same cycle -> pop and accept together, and the second word is delivered 4 accepts later.
REQ-038 Reset and abort test: rst after 2 bits -> out_valid=0, word_cnt=0, and the next 4 bits 1,0,1,0 yield 4'b1010; abort after 3 bits -> the next 4 bits form a fresh word.
REQ-039 Wrap test: 256 pops -> word_cnt returns to 0.
